// File: rtl/mips_defs_pkg.sv
// Shared MIPS core definitions: load opcodes and the bubble instruction word.
// Reused by the controller, the hazard unit and the M/W pipeline register.
package mips_defs;

  localparam logic [5:0]  OP_LW  = 6'h23;
  localparam logic [5:0]  OP_LH  = 6'h21;
  localparam logic [5:0]  OP_LHU = 6'h25;
  localparam logic [5:0]  OP_LB  = 6'h20;
  localparam logic [5:0]  OP_LBU = 6'h24;

  // sll $0,$0,0
  localparam logic [31:0] NOP_IR = 32'h0000_0000;

endpackage

// File: rtl/mw_pipe_reg_load_ext.sv
// Load-data lane selection and sign/zero extension, plus misalignment detection.
// Purely combinational; only the opcode field of the instruction is needed.
module load_ext
  import mips_defs::*;
(
  input  logic [5:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] DMRD,
  input  logic        validM,
  output logic [31:0] ext,
  output logic        mis
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = DMRD[7:0];
      2'd1:    byte_sel = DMRD[15:8];
      2'd2:    byte_sel = DMRD[23:16];
      default: byte_sel = DMRD[31:24];
    endcase
    half_sel = addr_lo[1] ? DMRD[31:16] : DMRD[15:0];
  end

  // Misaligned loads still return data from the truncated address.
  always_comb begin
    ext = 32'h0;
    mis = 1'b0;
    case (op)
      OP_LW: begin
        ext = DMRD;
        mis = (addr_lo != 2'b00);
      end
      OP_LH: begin
        ext = {{16{half_sel[15]}}, half_sel};
        mis = addr_lo[0];
      end
      OP_LHU: begin
        ext = {16'h0, half_sel};
        mis = addr_lo[0];
      end
      OP_LB:   ext = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  ext = {24'h0, byte_sel};
      default: ext = 32'h0;
    endcase
    if (!validM) mis = 1'b0;
  end

endmodule

// File: rtl/mw_pipe_reg.sv
// M/W pipeline register: latches the M-stage instruction, PC+8, ALU result and
// extended load data for writeback, and counts instructions retired into W.
module mw_pipe_reg #(
  parameter logic [31:0] NOP_IR = mips_defs::NOP_IR,
  parameter int          CNT_W  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic             validM,
  input  logic [31:0]      IRM,
  input  logic [31:0]      PC8M,
  input  logic [31:0]      AOM,
  input  logic [31:0]      DMRD,
  output logic [31:0]      IRW,
  output logic [31:0]      PC8W,
  output logic [31:0]      AOW,
  output logic [31:0]      DRW,
  output logic             validW,
  output logic             misalignW,
  output logic [CNT_W-1:0] instret
);

  logic [31:0]      ext;
  logic             mis;

  logic [31:0]      ir_q, ir_d;
  logic [31:0]      pc8_q, pc8_d;
  logic [31:0]      ao_q, ao_d;
  logic [31:0]      dr_q, dr_d;
  logic             valid_q, valid_d;
  logic             mis_q, mis_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  load_ext u_load_ext (
    .op      (IRM[31:26]),
    .addr_lo (AOM[1:0]),
    .DMRD    (DMRD),
    .validM  (validM),
    .ext     (ext),
    .mis     (mis)
  );

  // A flush takes precedence over a stall so a bubble is always inserted.
  always_comb begin
    ir_d    = ir_q;
    pc8_d   = pc8_q;
    ao_d    = ao_q;
    dr_d    = dr_q;
    valid_d = valid_q;
    mis_d   = mis_q;
    cnt_d   = cnt_q;
    if (clr) begin
      ir_d    = NOP_IR;
      pc8_d   = 32'h0;
      ao_d    = 32'h0;
      dr_d    = 32'h0;
      valid_d = 1'b0;
      mis_d   = 1'b0;
    end else if (en) begin
      ir_d    = IRM;
      pc8_d   = PC8M;
      ao_d    = AOM;
      dr_d    = ext;
      valid_d = validM;
      mis_d   = mis;
      if (validM) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ir_q    <= NOP_IR;
      pc8_q   <= 32'h0;
      ao_q    <= 32'h0;
      dr_q    <= 32'h0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      ir_q    <= ir_d;
      pc8_q   <= pc8_d;
      ao_q    <= ao_d;
      dr_q    <= dr_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
      cnt_q   <= cnt_d;
    end
  end

  assign IRW       = ir_q;
  assign PC8W      = pc8_q;
  assign AOW       = ao_q;
  assign DRW       = dr_q;
  assign validW    = valid_q;
  assign misalignW = mis_q;
  assign instret   = cnt_q;

endmodule

// File: tb/tb_mw_pipe_reg.sv
// Self-checking bench for mw_pipe_reg: directed test-plan steps followed by
// randomized traffic, compared against a behavioural model of the W-stage state.
module tb_mw_pipe_reg;

  logic        clk = 1'b0;
  logic        reset, en, clr, validM;
  logic [31:0] IRM, PC8M, AOM, DMRD;
  logic [31:0] IRW, PC8W, AOW, DRW;
  logic        validW, misalignW;
  logic [31:0] instret;
  logic [31:0] IRW4, PC8W4, AOW4, DRW4;
  logic        validW4, misalignW4;
  logic [3:0]  instret4;

  int checks = 0;
  int errors = 0;

  // Expected W-stage state
  logic [31:0] m_ir, m_pc8, m_ao, m_dr, m_cnt;
  logic        m_valid, m_mis;
  logic [3:0]  m_cnt4;

  always #5 clk = ~clk;

  mw_pipe_reg #(.NOP_IR(32'h0000_0000), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .validM(validM),
    .IRM(IRM), .PC8M(PC8M), .AOM(AOM), .DMRD(DMRD),
    .IRW(IRW), .PC8W(PC8W), .AOW(AOW), .DRW(DRW),
    .validW(validW), .misalignW(misalignW), .instret(instret)
  );

  // Narrow counter copy so wrap-around is reachable in a short run
  mw_pipe_reg #(.NOP_IR(32'h0000_0000), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .validM(validM),
    .IRM(IRM), .PC8M(PC8M), .AOM(AOM), .DMRD(DMRD),
    .IRW(IRW4), .PC8W(PC8W4), .AOW(AOW4), .DRW(DRW4),
    .validW(validW4), .misalignW(misalignW4), .instret(instret4)
  );

  function automatic logic [31:0] ref_ext(input logic [31:0] ir, input logic [31:0] ao,
                                          input logic [31:0] d);
    int unsigned op = ir[31:26];
    int unsigned a  = ao[1:0];
    int unsigned b  = (d >> (8 * a)) & 32'hFF;
    int unsigned h  = (d >> (16 * (a / 2))) & 32'hFFFF;
    case (op)
      'h23:    return d;
      'h20:    return (b >= 128) ? 32'(b - 256) : 32'(b);
      'h24:    return 32'(b);
      'h21:    return (h >= 32768) ? 32'(h - 65536) : 32'(h);
      'h25:    return 32'(h);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic ref_mis(input logic [31:0] ir, input logic [31:0] ao,
                                   input logic v);
    int unsigned op = ir[31:26];
    int unsigned a  = ao[1:0];
    if (!v) return 1'b0;
    if (op == 'h23) return a != 0;
    if (op == 'h21 || op == 'h25) return (a % 2) == 1;
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic e, input logic c, input logic v, input logic [31:0] ir,
                       input logic [31:0] pc8, input logic [31:0] ao, input logic [31:0] d);
    en = e; clr = c; validM = v; IRM = ir; PC8M = pc8; AOM = ao; DMRD = d;
  endtask

  // One clock: advance model from current inputs, then compare every output.
  task automatic tick();
    if (reset) begin
      m_ir = 0; m_pc8 = 0; m_ao = 0; m_dr = 0; m_valid = 0; m_mis = 0;
      m_cnt = 0; m_cnt4 = 0;
    end else if (clr) begin
      m_ir = 0; m_pc8 = 0; m_ao = 0; m_dr = 0; m_valid = 0; m_mis = 0;
    end else if (en) begin
      m_ir = IRM; m_pc8 = PC8M; m_ao = AOM;
      m_dr = ref_ext(IRM, AOM, DMRD);
      m_mis = ref_mis(IRM, AOM, validM);
      m_valid = validM;
      if (validM) begin
        m_cnt = m_cnt + 1;
        m_cnt4 = 4'((int'(m_cnt4) + 1) % 16);
      end
    end
    @(posedge clk);
    #1;
    chk("IRW", IRW, m_ir);
    chk("PC8W", PC8W, m_pc8);
    chk("AOW", AOW, m_ao);
    chk("DRW", DRW, m_dr);
    chk("validW", {31'h0, validW}, {31'h0, m_valid});
    chk("misalignW", {31'h0, misalignW}, {31'h0, m_mis});
    chk("instret", instret, m_cnt);
    chk("instret4", {28'h0, instret4}, {28'h0, m_cnt4});
    $display("t=%0t rst=%0b en=%0b clr=%0b v=%0b IRW=%h AOW=%h DRW=%h mis=%0b cnt=%0d",
             $time, reset, en, clr, validM, IRW, AOW, DRW, misalignW, instret);
  endtask

  initial begin
    logic [31:0] ir_rand;
    int unsigned sel;
    m_ir = 0; m_pc8 = 0; m_ao = 0; m_dr = 0; m_valid = 0; m_mis = 0; m_cnt = 0; m_cnt4 = 0;
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 32'h8C01_0004, 32'h0000_0108, 32'h10, 32'hDEAD_BEEF);
    tick();
    tick();
    chk("reset_IRW", IRW, 32'h0);
    chk("reset_instret", instret, 32'h0);

    reset = 1'b0;
    tick();
    chk("lw_DRW", DRW, 32'hDEAD_BEEF);
    chk("lw_mis", {31'h0, misalignW}, 32'h0);
    chk("lw_instret", instret, 32'd1);

    drive(1'b1, 1'b0, 1'b1, {6'h20, 26'h0}, 32'h10C, 32'h2, 32'h80FF_7F01); tick();
    chk("lb_DRW", DRW, 32'hFFFF_FFFF);
    drive(1'b1, 1'b0, 1'b1, {6'h24, 26'h0}, 32'h110, 32'h3, 32'h80FF_7F01); tick();
    chk("lbu_DRW", DRW, 32'h0000_0080);
    drive(1'b1, 1'b0, 1'b1, {6'h21, 26'h0}, 32'h114, 32'h2, 32'h80FF_7F01); tick();
    chk("lh_DRW", DRW, 32'hFFFF_80FF);
    drive(1'b1, 1'b0, 1'b1, {6'h25, 26'h0}, 32'h118, 32'h0, 32'h80FF_7F01); tick();
    chk("lhu_DRW", DRW, 32'h0000_7F01);

    drive(1'b1, 1'b0, 1'b1, 32'h8C01_0004, 32'h11C, 32'h13, 32'h1234_5678); tick();
    chk("lw_mis_flag", {31'h0, misalignW}, 32'h1);
    chk("lw_mis_DRW", DRW, 32'h1234_5678);
    drive(1'b1, 1'b0, 1'b1, {6'h21, 26'h0}, 32'h120, 32'h11, 32'h1234_5678); tick();
    chk("lh_mis_flag", {31'h0, misalignW}, 32'h1);
    drive(1'b1, 1'b0, 1'b1, 32'h0022_0821, 32'h124, 32'h13, 32'h1234_5678); tick();
    chk("addu_mis", {31'h0, misalignW}, 32'h0);
    chk("addu_DRW", DRW, 32'h0);

    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b1, 32'h8C00_0000 + i, 32'h200 + i, 32'h40 + i, 32'hA5A5_0000 + i);
      tick();
    end
    chk("stall_IRW", IRW, 32'h0022_0821);
    chk("stall_instret", instret, 32'd8);

    drive(1'b0, 1'b1, 1'b1, 32'h8C01_0004, 32'h300, 32'h10, 32'h1); tick();
    chk("flush_IRW", IRW, 32'h0);
    chk("flush_validW", {31'h0, validW}, 32'h0);
    chk("flush_instret", instret, 32'd8);

    drive(1'b1, 1'b0, 1'b0, 32'h8C01_0004, 32'h304, 32'h10, 32'h2); tick();
    chk("bubble_validW", {31'h0, validW}, 32'h0);
    chk("bubble_instret", instret, 32'd8);

    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 1'b1, 32'h2400_0000 + i, 32'h400 + 4 * i, 32'h50 + i, $urandom);
      tick();
    end
    chk("wrap_instret4", {28'h0, instret4}, 32'h0);
    chk("wrap_instret", instret, 32'd16);

    // Reset during a stall and during a flush
    reset = 1'b1; drive(1'b0, 1'b0, 1'b1, 32'h1, 32'h2, 32'h3, 32'h4); tick();
    chk("rst_stall_instret", instret, 32'h0);
    reset = 1'b0; drive(1'b1, 1'b0, 1'b1, 32'h8C00_0000, 32'h8, 32'h4, 32'h5); tick();
    reset = 1'b1; drive(1'b1, 1'b1, 1'b1, 32'h1, 32'h2, 32'h3, 32'h4); tick();
    chk("rst_flush_instret", instret, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 6);
      case (sel)
        0: ir_rand = {6'h23, 26'($urandom)};
        1: ir_rand = {6'h21, 26'($urandom)};
        2: ir_rand = {6'h25, 26'($urandom)};
        3: ir_rand = {6'h20, 26'($urandom)};
        4: ir_rand = {6'h24, 26'($urandom)};
        default: ir_rand = $urandom;
      endcase
      reset = ($urandom_range(0, 99) < 2);
      drive($urandom_range(0, 99) < 80, $urandom_range(0, 99) < 10,
            $urandom_range(0, 99) < 85, ir_rand, $urandom, $urandom, $urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
